// File: rtl/serial_pkg.sv
// Shared encodings and defaults for the serial subsystem.
package serial_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  localparam int DEFAULT_MAXBURST = 4;
endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone request wins, a tie goes to prio.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       sel,
  output logic       valid
);
  assign valid = |req;
  assign sel   = (req == 2'b11) ? prio : req[1];
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of one FIFO write port; grant one cycle after request, one byte/cycle,
// stalls without ack while fifo_full, grant rotates on last byte, burst limit or abandon.
module fifo_wr_arbiter
  import serial_pkg::*;
#(
  parameter int B        = 8,
  parameter int MAXBURST = DEFAULT_MAXBURST
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [B-1:0] data0,
  input  logic [B-1:0] data1,
  input  logic         last0,
  input  logic         last1,
  output logic         ack0,
  output logic         ack1,
  input  logic         fifo_full,
  output logic         fifo_wr,
  output logic [B-1:0] fifo_wdata,
  output logic [1:0]   grant,
  output logic         busy
);
  localparam int CW = $clog2(MAXBURST) + 1;

  state_t        state, state_nxt;
  logic          prio, prio_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    pick_req;
  logic          pick_sel, pick_valid;
  logic          burst_end, rel;

  // While granted only the other side is offered, so the picker yields the handover target.
  assign pick_req  = (state == ST_IDLE) ? {req1, req0} :
                     (state == ST_GNT0) ? {req1, 1'b0} : {1'b0, req0};
  assign burst_end = (cnt == CW'(MAXBURST - 1));
  assign busy      = (state != ST_IDLE);

  rr_pick2 u_pick (
    .req   (pick_req),
    .prio  (prio),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    prio_nxt   = prio;
    cnt_nxt    = cnt;
    fifo_wr    = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    fifo_wdata = '0;
    grant      = 2'b00;
    rel        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) state_nxt = pick_sel ? ST_GNT1 : ST_GNT0;
      end
      ST_GNT0: begin
        grant      = 2'b01;
        fifo_wr    = req0 & ~fifo_full;
        ack0       = fifo_wr;
        fifo_wdata = data0;
        rel        = (fifo_wr & (last0 | burst_end)) | ~req0;
      end
      ST_GNT1: begin
        grant      = 2'b10;
        fifo_wr    = req1 & ~fifo_full;
        ack1       = fifo_wr;
        fifo_wdata = data1;
        rel        = (fifo_wr & (last1 | burst_end)) | ~req1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (fifo_wr) cnt_nxt = cnt + 1'b1;
    if (rel) begin
      cnt_nxt   = '0;
      prio_nxt  = (state == ST_GNT0);
      state_nxt = pick_valid ? (pick_sel ? ST_GNT1 : ST_GNT0) : ST_IDLE;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a message-level reference model.
module tb_fifo_wr_arbiter;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 0, req1 = 0, last0 = 0, last1 = 0, fifo_full = 0;
  logic [7:0] data0 = 0, data1 = 0;
  logic       ack0, ack1, fifo_wr, busy;
  logic [7:0] fifo_wdata;
  logic [1:0] grant;

  fifo_wr_arbiter #(.B(8), .MAXBURST(MB)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .last0(last0), .last1(last1), .ack0(ack0), .ack1(ack1), .fifo_full(fifo_full),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Pending bytes per requester: {last, data}.
  logic [8:0] pend0[$];
  logic [8:0] pend1[$];
  logic [7:0] obs_fifo[$];
  logic [7:0] exp_fifo[$];
  logic [7:0] want[$];
  bit         en0 = 1, en1 = 1;

  // Model: current owner (-1 none), tie-break favourite, bytes taken this grant.
  int owner = -1;
  int prio  = 0;
  int taken = 0;

  task automatic check(string tag, logic [14:0] obs, logic [14:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [14:0] outs();
    return {grant, busy, fifo_wr, ack1, ack0, fifo_wdata};
  endfunction

  task automatic push_msg(int n, int len, logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      if (n == 0) pend0.push_back({(i == len - 1), base + 8'(i)});
      else        pend1.push_back({(i == len - 1), base + 8'(i)});
    end
  endtask

  task automatic cycle();
    logic [1:0] rq;
    logic       lst[2];
    logic [7:0] dat[2];
    logic [1:0] e_gnt, e_ack;
    logic       e_wr, e_busy, rel;
    logic [7:0] e_dat;
    int o;
    rq[0] = en0 && pend0.size() != 0;
    rq[1] = en1 && pend1.size() != 0;
    dat[0] = rq[0] ? pend0[0][7:0] : 8'h00;
    dat[1] = rq[1] ? pend1[0][7:0] : 8'h00;
    lst[0] = rq[0] ? pend0[0][8] : 1'b0;
    lst[1] = rq[1] ? pend1[0][8] : 1'b0;
    req0 = rq[0]; req1 = rq[1];
    data0 = dat[0]; data1 = dat[1];
    last0 = lst[0]; last1 = lst[1];
    #3;
    e_gnt = 2'b00; e_ack = 2'b00; e_wr = 1'b0; e_dat = 8'h00; e_busy = 1'b0;
    if (!reset && owner >= 0) begin
      e_busy = 1'b1;
      e_gnt[owner] = 1'b1;
      e_wr = rq[owner] && !fifo_full;
      e_ack[owner] = e_wr;
      e_dat = dat[owner];
    end
    check("outputs", outs(), {e_gnt, e_busy, e_wr, e_ack, e_dat});
    if (fifo_wr && !fifo_full) obs_fifo.push_back(fifo_wdata);
    @(posedge clk);
    cyc++;
    if (reset) begin
      owner = -1; prio = 0; taken = 0;
    end else if (owner < 0) begin
      if (rq == 2'b11) owner = prio;
      else if (rq != 2'b00) owner = rq[1] ? 1 : 0;
    end else begin
      o = owner;
      if (e_wr) begin
        taken++;
        exp_fifo.push_back(e_dat);
        if (o == 0) void'(pend0.pop_front());
        else        void'(pend1.pop_front());
      end
      rel = (e_wr && (lst[o] || taken == MB)) || !rq[o];
      if (rel) begin
        taken = 0;
        prio  = 1 - o;
        owner = rq[1 - o] ? 1 - o : -1;
      end
    end
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_stream(string tag);
    bit same;
    same = (obs_fifo.size() == want.size());
    if (same) for (int i = 0; i < want.size(); i++) if (obs_fifo[i] !== want[i]) same = 0;
    checks++;
    assert (same) else begin
      failures++;
      $error("FAIL %s observed=%p expected=%p", tag, obs_fifo, want);
    end
    obs_fifo.delete();
    exp_fifo.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    check("reset_outputs", outs(), 15'h0);
    do_reset();

    // Single requester, three-byte message.
    push_msg(0, 3, 8'h41);
    run(6);
    want = '{8'h41, 8'h42, 8'h43};
    check_stream("single_msg");

    // Simultaneous requests straight after reset: 0 first, then 1 with no idle gap.
    do_reset();
    push_msg(0, 2, 8'hA0);
    push_msg(1, 1, 8'hB0);
    run(6);
    want = '{8'hA0, 8'hA1, 8'hB0};
    check_stream("simultaneous");

    // Burst limit rotation.
    push_msg(0, 6, 8'h10);
    push_msg(1, 3, 8'h20);
    run(14);
    want = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h14, 8'h15};
    check_stream("burst_limit");

    // FIFO full stall mid-message.
    push_msg(0, 5, 8'h30);
    run(3);
    fifo_full = 1'b1;
    run(3);
    fifo_full = 1'b0;
    run(7);
    want = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
    check_stream("full_stall");

    // Requester 1 abandons mid-message; grant moves to 0.
    push_msg(1, 4, 8'h40);
    run(3);
    en1 = 0;
    push_msg(0, 1, 8'h50);
    cycle();
    en1 = 1;
    run(6);
    want = '{8'h40, 8'h41, 8'h50, 8'h42, 8'h43};
    check_stream("abandon");

    // Asynchronous reset between edges while a burst is in progress.
    push_msg(0, 8, 8'h60);
    push_msg(1, 2, 8'h70);
    run(3);
    #1 reset = 1'b1;
    #1 check("async_reset", outs(), 15'h0);
    @(posedge clk); #1;
    cyc++;
    owner = -1; prio = 0; taken = 0;
    check("reset_held", outs(), 15'h0);
    reset = 1'b0;
    run(20);
    obs_fifo.delete();
    exp_fifo.delete();

    // Randomized traffic with random stalls and occasional abandons.
    for (int i = 0; i < 400; i++) begin
      if (pend0.size() < 4 && $urandom_range(3) == 0) push_msg(0, $urandom_range(1, 7), 8'($urandom));
      if (pend1.size() < 4 && $urandom_range(3) == 0) push_msg(1, $urandom_range(1, 7), 8'($urandom));
      fifo_full = ($urandom_range(3) == 0);
      en0 = ($urandom_range(15) != 0);
      en1 = ($urandom_range(15) != 0);
      cycle();
    end
    fifo_full = 1'b0;
    en0 = 1; en1 = 1;
    for (int i = 0; i < 300 && (pend0.size() != 0 || pend1.size() != 0 || owner >= 0); i++) cycle();
    checks++;
    assert (pend0.size() == 0 && pend1.size() == 0) else begin
      failures++;
      $error("FAIL drain observed=%0d/%0d pending expected=0/0", pend0.size(), pend1.size());
    end
    want = exp_fifo;
    check_stream("random_stream");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
